y86_bus_arbiter: RTL and testbench
==================================

Y86_BUS_ARBITER -- requirements
Module: y86_bus_arbiter

Interface
REQ-001 Parameter: WAIT_MAX, default 15, maximum ACCESS cycles without bus_ack before the transfer is aborted.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on the clk rising edge only.
REQ-004 c_A / c_wdata  input  32/32  core requester address and write data.
REQ-005 c_RE / c_WE  input  1/1  core read or write request, held until c_ready.
REQ-006 c_rdata / c_ready  output  32/1  core read data and one-cycle completion pulse.
REQ-007 d_A, d_wdata, d_RE, d_WE, d_rdata, d_ready: debug/DMA requester ports, same widths and meaning as the c_ ports.
REQ-008 bus_A / bus_out  output  32/32  shared memory address and write data.
REQ-009 bus_RE / bus_WE  output  1/1  shared memory read and write strobes.
REQ-010 bus_in / bus_ack  input  32/1  memory read data and access-complete indication.
REQ-011 timeout  output  1  one-cycle pulse when a transfer aborts on WAIT_MAX.

Function
REQ-012 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-013 IDLE: if any RE or WE is high, the block SHALL select a winner, latch its address, data and op into internal registers, and enter ACCESS next cycle; otherwise it stays in IDLE.
REQ-014 Arbitration SHALL be round-robin on last_grant: on a simultaneous request, the requester not granted last wins; a single requester always wins.
REQ-015 If RE and WE are both high from one requester, the request SHALL be treated as a write.
REQ-016 ACCESS: bus_A, bus_out and exactly one of bus_RE/bus_WE SHALL be driven from the latched registers; all bus outputs SHALL be 0 in IDLE and RESP.
REQ-017 ACCESS with bus_ack=1 SHALL capture bus_in (reads only) into the response register and enter RESP.
REQ-018 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without bus_ack.
REQ-019 When the counter reaches WAIT_MAX with no ack, the block SHALL enter RESP with response data 0 and pulse timeout in that RESP cycle.
REQ-020 bus_ack in the same cycle the counter hits WAIT_MAX SHALL count as success, with no timeout.
REQ-021 RESP SHALL pulse the granted requester's ready for exactly one cycle, present rdata, update last_grant, and return to IDLE.
REQ-022 rdata SHALL hold its value until the next RESP for that requester; write completions SHALL leave rdata unchanged.
REQ-023 Minimum latency: a request sampled in IDLE at cycle N with ack at N+1 SHALL give ready at N+2.
REQ-024 A requester SHALL drop or replace its request in the cycle after ready; IDLE resamples in that cycle, so back-to-back transfers are possible every 3 cycles.
REQ-025 A request change during ACCESS/RESP SHALL NOT affect the transfer in flight, because it runs from the latched registers.
REQ-026 bus_ack outside ACCESS SHALL be ignored.

Reset
REQ-027 rst=0 at a rising edge SHALL force IDLE, counter 0, last_grant=debug (core wins first tie), c_rdata=d_rdata=0, and all ready, timeout and bus outputs 0.
REQ-028 Reset during ACCESS SHALL abandon the transfer with no ready pulse; bus strobes SHALL be 0 in the cycle after the reset edge.

Structure
REQ-029 Package y86_bus_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), the requester-id encoding (CORE=0, DBG=1) and the WAIT_MAX default.
REQ-030 Round-robin selection SHALL be a combinational sub-module y86_rr_pick2 (inputs: two requests and last_grant; output: winner id and valid).

Verification
REQ-031 Core read A=0x100, bus_ack one cycle after ACCESS entry with bus_in=0xDEADBEEF -> c_ready at N+2, c_rdata=0xDEADBEEF, bus_RE high for exactly 1 cycle.
REQ-032 Core and debug request together after reset -> core served first; debug served next with its ready 3 cycles after c_ready; a second tie then goes to core again.
REQ-033 Debug write A=0x40, wdata=0x5A5A5A5A, ack after 3 wait cycles -> bus_WE high 4 cycles with bus_out=0x5A5A5A5A, then d_ready; d_rdata unchanged.
REQ-034 Core read, bus_ack never asserted, WAIT_MAX=15 -> timeout and c_ready pulse together after 15 ACCESS cycles, c_rdata=0, FSM back to IDLE.
REQ-035 rst low during ACCESS -> no ready pulse, bus_RE=bus_WE=0 next cycle; a later request completes normally, with core winning a tie.
REQ-036 Core changes c_A from 0x100 to 0x200 mid-ACCESS -> bus_A stays 0x100 until RESP.

Source files
------------

// File: rtl/y86_bus_pkg.sv
// Shared types for the two-requester Y86 memory bus arbiter.
// State encoding, requester ids and the default wait budget.
package y86_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    CORE = 1'b0,
    DBG  = 1'b1
  } rid_t;

  localparam int WAIT_MAX_DEF = 15;

endpackage

// File: rtl/y86_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester
// that did not win last time is chosen.
module y86_rr_pick2
  import y86_bus_pkg::*;
(
  input  logic i_req_c,
  input  logic i_req_d,
  input  rid_t i_last,
  output rid_t o_win,
  output logic o_valid
);

  always_comb begin
    o_valid = i_req_c | i_req_d;
    o_win   = CORE;
    if (i_req_c && i_req_d)
      o_win = (i_last == CORE) ? DBG : CORE;
    else if (i_req_d)
      o_win = DBG;
  end

endmodule

// File: rtl/y86_bus_arbiter.sv
// Shares one memory bus between the core and a debug/DMA port.
// Requests are latched in IDLE, so the bus runs from registers.
module y86_bus_arbiter
  import y86_bus_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] c_A,
  input  logic [31:0] c_wdata,
  input  logic        c_RE,
  input  logic        c_WE,
  output logic [31:0] c_rdata,
  output logic        c_ready,
  input  logic [31:0] d_A,
  input  logic [31:0] d_wdata,
  input  logic        d_RE,
  input  logic        d_WE,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] bus_A,
  output logic [31:0] bus_out,
  output logic        bus_RE,
  output logic        bus_WE,
  input  logic [31:0] bus_in,
  input  logic        bus_ack,
  output logic        timeout
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  state_t      r_state, w_next;
  rid_t        r_gnt, r_last, w_win;
  logic        w_valid;
  logic [31:0] r_addr, r_wdata;
  logic        r_wr;
  logic [CW-1:0] r_cnt, w_cnt_inc;
  logic        w_expire;
  logic        r_to;
  logic [31:0] r_c_rdata, r_d_rdata;
  logic [31:0] w_rsp;
  logic        w_acc;

  y86_rr_pick2 u_pick (
    .i_req_c (c_RE | c_WE),
    .i_req_d (d_RE | d_WE),
    .i_last  (r_last),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  assign w_cnt_inc = r_cnt + 1'b1;
  // ack on the final allowed cycle still wins over the abort
  assign w_expire  = !bus_ack && (w_cnt_inc == CW'(WAIT_MAX));
  assign w_rsp     = bus_ack ? bus_in : 32'd0;
  assign w_acc     = (r_state == ACCESS);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_valid) w_next = ACCESS;
      ACCESS:  if (bus_ack || w_expire) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gnt     <= CORE;
      r_last    <= DBG;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wr      <= 1'b0;
      r_cnt     <= '0;
      r_to      <= 1'b0;
      r_c_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_to <= 1'b0;
          if (w_valid) begin
            r_gnt   <= w_win;
            r_addr  <= (w_win == CORE) ? c_A : d_A;
            r_wdata <= (w_win == CORE) ? c_wdata : d_wdata;
            r_wr    <= (w_win == CORE) ? c_WE : d_WE;
            r_cnt   <= '0;
          end
        end
        ACCESS: begin
          if (!bus_ack) r_cnt <= w_cnt_inc;
          if (bus_ack || w_expire) begin
            r_to <= !bus_ack;
            if (!r_wr) begin
              if (r_gnt == CORE) r_c_rdata <= w_rsp;
              else               r_d_rdata <= w_rsp;
            end
          end
        end
        RESP: begin
          r_last <= r_gnt;
          r_to   <= 1'b0;
        end
        default: r_to <= 1'b0;
      endcase
    end
  end

  assign bus_A   = w_acc ? r_addr : 32'd0;
  assign bus_out = w_acc ? r_wdata : 32'd0;
  assign bus_RE  = w_acc && !r_wr;
  assign bus_WE  = w_acc && r_wr;

  assign c_ready = (r_state == RESP) && (r_gnt == CORE);
  assign d_ready = (r_state == RESP) && (r_gnt == DBG);
  assign timeout = (r_state == RESP) && r_to;
  assign c_rdata = r_c_rdata;
  assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_y86_bus_arbiter.sv
// Directed bench for the Y86 bus arbiter: inputs change and
// outputs are checked on the falling clock edge.
module tb_y86_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] c_A, c_wdata, c_rdata;
  logic        c_RE, c_WE, c_ready;
  logic [31:0] d_A, d_wdata, d_rdata;
  logic        d_RE, d_WE, d_ready;
  logic [31:0] bus_A, bus_out, bus_in;
  logic        bus_RE, bus_WE, bus_ack, timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  y86_bus_arbiter #(.WAIT_MAX(15)) dut (
    .clk     (clk),
    .rst     (rst),
    .c_A     (c_A),
    .c_wdata (c_wdata),
    .c_RE    (c_RE),
    .c_WE    (c_WE),
    .c_rdata (c_rdata),
    .c_ready (c_ready),
    .d_A     (d_A),
    .d_wdata (d_wdata),
    .d_RE    (d_RE),
    .d_WE    (d_WE),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .bus_A   (bus_A),
    .bus_out (bus_out),
    .bus_RE  (bus_RE),
    .bus_WE  (bus_WE),
    .bus_in  (bus_in),
    .bus_ack (bus_ack),
    .timeout (timeout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_reqs();
    c_RE = 0; c_WE = 0; d_RE = 0; d_WE = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    tick();
    rst = 1;
  endtask

  initial begin
    rst = 0;
    c_A = 0; c_wdata = 0; d_A = 0; d_wdata = 0;
    idle_reqs();
    bus_in = 0; bus_ack = 0;
    tick(); tick();

    chk("rst_c_ready", c_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_bus_RE", bus_RE, 0);
    chk("rst_bus_WE", bus_WE, 0);
    chk("rst_bus_A", bus_A, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1;
    tick();

    // core read with minimum latency
    c_A = 32'h100; c_RE = 1;
    tick();
    chk("rd_bus_RE", bus_RE, 1);
    chk("rd_bus_WE", bus_WE, 0);
    chk("rd_bus_A", bus_A, 32'h100);
    chk("rd_no_ready", c_ready, 0);
    bus_ack = 1; bus_in = 32'hDEADBEEF;
    tick();
    chk("rd_c_ready", c_ready, 1);
    chk("rd_c_rdata", c_rdata, 32'hDEADBEEF);
    chk("rd_resp_bus_RE", bus_RE, 0);
    chk("rd_resp_bus_A", bus_A, 0);
    idle_reqs(); bus_ack = 0;
    tick();
    chk("rd_ready_pulse", c_ready, 0);
    chk("rd_idle_bus_RE", bus_RE, 0);

    // tie after reset: core, then debug, then core
    do_reset();
    chk("tie_rst_rdata", c_rdata, 0);
    c_A = 32'h10; c_RE = 1;
    d_A = 32'h20; d_RE = 1;
    bus_ack = 1; bus_in = 32'h11111111;
    tick();
    chk("tie1_bus_A", bus_A, 32'h10);
    tick();
    chk("tie1_c_ready", c_ready, 1);
    chk("tie1_d_ready", d_ready, 0);
    chk("tie1_c_rdata", c_rdata, 32'h11111111);
    c_RE = 0; bus_in = 32'h22222222;
    tick();
    chk("tie_idle_ready", c_ready, 0);
    chk("tie_idle_bus_RE", bus_RE, 0);
    tick();
    chk("tie2_bus_A", bus_A, 32'h20);
    tick();
    chk("tie2_d_ready", d_ready, 1);
    chk("tie2_c_ready", c_ready, 0);
    chk("tie2_d_rdata", d_rdata, 32'h22222222);
    chk("tie2_c_rdata", c_rdata, 32'h11111111);
    c_A = 32'h30; c_RE = 1;
    bus_in = 32'h33333333;
    tick();
    tick();
    chk("tie3_bus_A", bus_A, 32'h30);
    tick();
    chk("tie3_c_ready", c_ready, 1);
    chk("tie3_c_rdata", c_rdata, 32'h33333333);
    idle_reqs(); bus_ack = 0;
    tick();

    // debug write with RE+WE, three wait cycles
    d_A = 32'h40; d_wdata = 32'h5A5A5A5A;
    d_RE = 1; d_WE = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wr_bus_WE_%0d", i), bus_WE, 1);
      chk($sformatf("wr_bus_RE_%0d", i), bus_RE, 0);
      chk($sformatf("wr_bus_out_%0d", i), bus_out, 32'h5A5A5A5A);
      chk($sformatf("wr_bus_A_%0d", i), bus_A, 32'h40);
      chk($sformatf("wr_no_ready_%0d", i), d_ready, 0);
      if (i == 3) begin
        bus_ack = 1; bus_in = 32'hFFFFFFFF;
      end
      tick();
    end
    chk("wr_d_ready", d_ready, 1);
    chk("wr_bus_WE_off", bus_WE, 0);
    chk("wr_d_rdata_kept", d_rdata, 32'h22222222);
    chk("wr_no_timeout", timeout, 0);
    idle_reqs(); bus_ack = 0;
    tick();

    // core read that never gets an ack
    c_A = 32'h104; c_RE = 1;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("to_bus_RE_%0d", i), bus_RE, 1);
      chk($sformatf("to_pending_%0d", i), timeout, 0);
      tick();
    end
    chk("to_timeout", timeout, 1);
    chk("to_c_ready", c_ready, 1);
    chk("to_c_rdata", c_rdata, 0);
    chk("to_bus_RE_off", bus_RE, 0);
    idle_reqs();
    tick();
    chk("to_pulse_end", timeout, 0);
    chk("to_ready_end", c_ready, 0);

    // ack on the last allowed cycle is a success
    c_A = 32'h108; c_RE = 1;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("edge_bus_RE_%0d", i), bus_RE, 1);
      if (i == 14) begin
        bus_ack = 1; bus_in = 32'hCAFEF00D;
      end
      tick();
    end
    chk("edge_timeout", timeout, 0);
    chk("edge_c_ready", c_ready, 1);
    chk("edge_c_rdata", c_rdata, 32'hCAFEF00D);
    idle_reqs(); bus_ack = 0;
    tick();

    // reset in the middle of an access
    c_A = 32'h10C; c_RE = 1;
    tick();
    chk("ra_bus_RE", bus_RE, 1);
    rst = 0; idle_reqs();
    tick();
    chk("ra_bus_RE_off", bus_RE, 0);
    chk("ra_bus_WE_off", bus_WE, 0);
    chk("ra_no_ready", c_ready, 0);
    chk("ra_rdata_clr", c_rdata, 0);
    rst = 1;
    tick();
    chk("ra_still_idle", c_ready, 0);
    c_A = 32'h50; c_RE = 1;
    d_A = 32'h60; d_RE = 1;
    bus_ack = 1; bus_in = 32'h12345678;
    tick();
    chk("ra_tie_bus_A", bus_A, 32'h50);
    tick();
    chk("ra_c_ready", c_ready, 1);
    chk("ra_d_ready", d_ready, 0);
    chk("ra_c_rdata", c_rdata, 32'h12345678);
    idle_reqs(); bus_ack = 0;
    tick();
    tick();

    // request change while in flight
    c_A = 32'h100; c_RE = 1;
    tick();
    chk("mid_bus_A0", bus_A, 32'h100);
    c_A = 32'h200;
    tick();
    chk("mid_bus_A1", bus_A, 32'h100);
    bus_ack = 1; bus_in = 32'hA5A5A5A5;
    tick();
    chk("mid_c_ready", c_ready, 1);
    chk("mid_c_rdata", c_rdata, 32'hA5A5A5A5);
    chk("mid_resp_bus_A", bus_A, 0);
    idle_reqs(); bus_ack = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
